// File: rtl/bit_scan8_if.sv
// Word-in / index-out bus of the bit scanner.
// A transfer completes on a rising clk edge where valid and ready are both high; a source holds
// its payload and valid steady until that edge, and ready may be asserted without waiting for valid.
interface bit_scan8_if #(
    parameter int WIDTH = 8
);
    localparam int IDX_W = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_index;
    logic             out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_index, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_index, out_last
    );
endinterface

// File: rtl/bit_scan8.sv
// Accepts a word and emits the index of each set bit, lowest first, one per output transfer.
module bit_scan8 #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    bit_scan8_if.slave    bus,
    output logic          zero_seen,
    output logic          busy,
    output logic          state_dbg
);
    localparam int IDX_W = $clog2(WIDTH);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] pending;
    logic [IDX_W-1:0] low_idx;
    logic             one_hot;

    // Downward loop so the lowest set bit wins.
    always_comb begin
        low_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pending[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    assign one_hot = (pending != '0) && ((pending & (pending - WIDTH'(1))) == '0);

    // Gating with reset keeps in_ready low for the whole reset interval.
    assign bus.in_ready  = (state == IDLE) && !reset;
    assign bus.out_valid = (state == SCAN);
    assign bus.out_index = low_idx;
    assign bus.out_last  = one_hot;
    assign busy          = (state == SCAN);
    assign state_dbg     = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pending   <= '0;
            zero_seen <= 1'b0;
        end else begin
            zero_seen <= 1'b0;
            if (state == IDLE) begin
                if (bus.in_valid) begin
                    if (bus.in_data != '0) begin
                        pending <= bus.in_data;
                        state   <= SCAN;
                    end else begin
                        zero_seen <= 1'b1;
                    end
                end
            end else begin
                if (bus.out_ready) begin
                    // Clearing the lowest set bit is the same as clearing bit low_idx.
                    pending <= pending & (pending - WIDTH'(1));
                    if (one_hot) begin
                        state <= IDLE;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_bit_scan8.sv
// Directed and random checks of bit_scan8 with a queue-based scoreboard on the output beats.
module tb_bit_scan8;
    logic clk;
    logic reset;
    logic zero_seen;
    logic busy;
    logic state_dbg;

    int n_tests = 0;
    int n_fail  = 0;
    int beats = 0;
    int pop_total = 0;
    int zero_pulses = 0;
    int zero_words = 0;

    logic [3:0] exp_q[$];
    logic       zexp;

    bit_scan8_if #(.WIDTH(8)) bus ();

    bit_scan8 #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .zero_seen (zero_seen),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: one beat expected per set bit, lowest first, last flag on the highest bit
    always @(negedge clk) begin
        if (reset) begin
            pop_total = pop_total - exp_q.size();
            exp_q.delete();
            zexp = 1'b0;
        end else begin
            logic [3:0] e;
            logic [7:0] d;
            check("zero_seen", zero_seen, zexp);
            check("zero_vs_valid", zero_seen & bus.out_valid, 0);
            if (zero_seen) zero_pulses++;
            if (bus.out_valid && bus.out_ready) begin
                beats++;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_last_idx", {bus.out_last, bus.out_index}, e);
                end
            end
            zexp = bus.in_valid && bus.in_ready && (bus.in_data == 8'h00);
            if (bus.in_valid && bus.in_ready) begin
                d = bus.in_data;
                if (d == 8'h00) zero_words++;
                for (int i = 0; i < 8; i++) begin
                    if (d[i]) begin
                        exp_q.push_back({((d >> (i + 1)) == 8'h00), 3'(i)});
                        pop_total++;
                    end
                end
            end
        end
    end

    // Driver: hold the word until accepted; returns 1 ns after the accepting edge
    task automatic send_word(input logic [7:0] d, output int waits);
        logic took;
        waits = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        do begin
            @(negedge clk);
            took = bus.in_ready;
            @(posedge clk);
            #1;
            if (!took) waits++;
        end while (!took && waits < 50);
        if (!took) check("accept_timeout", 0, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            if (!busy && !bus.out_valid) break;
            tick();
        end
        check("idle_timeout", busy, 0);
    endtask

    initial begin
        int w;
        int hs;
        logic hold;
        logic [2:0] pi;
        logic pl;
        logic took;
        logic [1:0] sel;

        reset = 1'b1;
        zexp = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b1;
        #1;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_zero_seen", zero_seen, 0);
        check("rst_busy", busy, 0);
        check("rst_index", bus.out_index, 0);
        check("rst_last", bus.out_last, 0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", bus.in_ready, 1);

        // 1: 1010_0100 -> 2, 5, 7
        send_word(8'hA4, w);
        check("t1_valid", bus.out_valid, 1);
        check("t1_idx0", bus.out_index, 2);
        check("t1_last0", bus.out_last, 0);
        check("t1_in_ready_scan", bus.in_ready, 0);
        tick();
        check("t1_idx1", bus.out_index, 5);
        check("t1_last1", bus.out_last, 0);
        tick();
        check("t1_idx2", bus.out_index, 7);
        check("t1_last2", bus.out_last, 1);
        tick();
        check("t1_in_ready_after", bus.in_ready, 1);
        check("t1_valid_after", bus.out_valid, 0);

        // 2: zero word
        send_word(8'h00, w);
        check("t2_zero_seen", zero_seen, 1);
        check("t2_valid", bus.out_valid, 0);
        check("t2_in_ready", bus.in_ready, 1);
        tick();
        check("t2_zero_seen_drop", zero_seen, 0);
        check("t2_in_ready2", bus.in_ready, 1);

        // 3: all ones with out_ready toggling
        send_word(8'hFF, w);
        check("t3_first_idx", bus.out_index, 0);
        hs = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            bus.out_ready = (cyc % 2 == 0);
            hold = !bus.out_ready;
            pi = bus.out_index;
            pl = bus.out_last;
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) hs++;
            tick();
            if (hold) begin
                check("t3_idx_hold", bus.out_index, pi);
                check("t3_last_hold", bus.out_last, pl);
            end
            if (!busy) break;
        end
        check("t3_handshakes", hs, 8);
        bus.out_ready = 1'b1;

        // 4: single bit, then a word held through SCAN
        send_word(8'h80, w);
        check("t4_idx", bus.out_index, 7);
        check("t4_last", bus.out_last, 1);
        send_word(8'h01, w);
        check("t4_wait_cycles", w, 1);
        check("t4_idx2", bus.out_index, 0);
        check("t4_last2", bus.out_last, 1);
        tick();
        check("t4_valid_end", bus.out_valid, 0);

        // 5: reset mid-scan
        send_word(8'h0F, w);
        check("t5_idx0", bus.out_index, 0);
        tick();
        check("t5_idx1", bus.out_index, 1);
        tick();
        check("t5_idx2", bus.out_index, 2);
        reset = 1'b1;
        #1;
        check("t5_rst_valid", bus.out_valid, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_in_ready", bus.in_ready, 0);
        check("t5_rst_index", bus.out_index, 0);
        check("t5_rst_last", bus.out_last, 0);
        tick();
        reset = 1'b0;
        #1;
        check("t5_in_ready", bus.in_ready, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t5_no_leftover", bus.out_valid, 0);
        end

        // 6: random words and back-pressure
        took = 1'b0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            if (!bus.in_valid || took) begin
                bus.in_valid = ($urandom_range(0, 1) == 1);
                sel = 2'($urandom_range(0, 3));
                case (sel)
                    2'd0:    bus.in_data = 8'h00;
                    2'd1:    bus.in_data = 8'h01 << $urandom_range(0, 7);
                    default: bus.in_data = 8'($urandom_range(0, 255));
                endcase
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            took = bus.in_valid && bus.in_ready;
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        wait_idle();
        tick();
        tick();
        check("queue_drained", exp_q.size(), 0);
        check("beats_vs_popcount", beats, pop_total);
        check("zero_pulses_vs_words", zero_pulses, zero_words);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
